// File: rtl/srrc_fir_sym_pipe.sv
`default_nettype none
// ============================================================================
// Module   : srrc_fir_sym_pipe
// Brief    : Fully pipelined symmetric SRRC receive FIR with shadow/active
//            coefficient banks and rounded output. Define SRRC_SAT_EN to
//            saturate the output; otherwise it wraps.
// Revision : 1.0 - initial release
// ============================================================================
module srrc_fir_sym_pipe #(
    parameter int DATA_W    = 18,
    parameter int COEF_W    = 18,
    parameter int NUM_TAPS  = 31,
    parameter int OUT_SHIFT = 17
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic signed [DATA_W-1:0]               x_in,
    input  logic                                   coef_we,
    input  logic [$clog2((NUM_TAPS+1)/2)-1:0]      coef_addr,
    input  logic signed [COEF_W-1:0]               coef_data,
    input  logic                                   coef_commit,
    output logic                                   out_valid,
    output logic signed [DATA_W-1:0]               y
);

    localparam int c_U      = (NUM_TAPS + 1) / 2;
    localparam int c_T      = $clog2(c_U);
    localparam int c_P      = 1 << c_T;
    localparam int c_PRE_W  = DATA_W + 1;
    localparam int c_PROD_W = c_PRE_W + COEF_W;
    localparam int c_ACC_W  = c_PROD_W + c_T;
    localparam int c_RND_W  = c_ACC_W + 1;
    localparam logic signed [COEF_W-1:0] c_UNIT = {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic [c_RND_W-1:0] c_HALF = {{(c_RND_W-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);

    logic signed [DATA_W-1:0]   r_dly    [NUM_TAPS];
    logic signed [c_PRE_W-1:0]  r_pre    [c_U];
    logic signed [c_PROD_W-1:0] r_prod   [c_U];
    logic signed [COEF_W-1:0]   r_shadow [c_U];
    logic signed [COEF_W-1:0]   r_active [c_U];
    logic signed [c_ACC_W-1:0]  w_leaf   [c_P];
    logic signed [c_ACC_W-1:0]  w_node   [1:c_P-1];
    logic                       r_v_dly;
    logic                       r_v_pre;
    logic                       r_v_prod;
    logic [c_T-1:0]             r_v_tree;
    logic                       w_wr_ok;

    assign w_wr_ok = coef_we && (32'(coef_addr) < c_U);

    // Commit copies the bank including a same-cycle write (write-through)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_U; i++) begin
                r_shadow[i] <= (i == c_U - 1) ? c_UNIT : '0;
                r_active[i] <= (i == c_U - 1) ? c_UNIT : '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_shadow[coef_addr] <= coef_data;
            end
            if (coef_commit) begin
                for (int i = 0; i < c_U; i++) begin
                    r_active[i] <= (w_wr_ok && (32'(coef_addr) == i)) ? coef_data : r_shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_dly[i] <= '0;
            end
            r_v_dly <= 1'b0;
        end else begin
            r_v_dly <= in_valid;
            if (in_valid) begin
                r_dly[0] <= x_in;
                for (int i = 1; i < NUM_TAPS; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_U; i++) begin
                r_pre[i]  <= '0;
                r_prod[i] <= '0;
            end
            r_v_pre  <= 1'b0;
            r_v_prod <= 1'b0;
        end else begin
            r_v_pre  <= r_v_dly;
            r_v_prod <= r_v_pre;
            for (int i = 0; i < c_U - 1; i++) begin
                r_pre[i] <= {r_dly[i][DATA_W-1], r_dly[i]}
                          + {r_dly[NUM_TAPS-1-i][DATA_W-1], r_dly[NUM_TAPS-1-i]};
            end
            r_pre[c_U-1] <= {r_dly[c_U-1][DATA_W-1], r_dly[c_U-1]};
            // Operands sign-extended to full product width; low bits are exact
            for (int i = 0; i < c_U; i++) begin
                r_prod[i] <= {{COEF_W{r_pre[i][c_PRE_W-1]}}, r_pre[i]}
                           * {{c_PRE_W{r_active[i][COEF_W-1]}}, r_active[i]};
            end
        end
    end

    // Leaves beyond U are zero, so an unpaired element passes through its node
    for (genvar i = 0; i < c_P; i++) begin : g_leaf
        if (i < c_U) begin : g_live
            assign w_leaf[i] = {{c_T{r_prod[i][c_PROD_W-1]}}, r_prod[i]};
        end else begin : g_pad
            assign w_leaf[i] = '0;
        end
    end

    for (genvar n = 1; n < c_P; n++) begin : g_node
        logic signed [c_ACC_W-1:0] w_a;
        logic signed [c_ACC_W-1:0] w_b;
        logic signed [c_ACC_W-1:0] r_sum;
        if (2 * n >= c_P) begin : g_from_leaf
            assign w_a = w_leaf[2*n - c_P];
            assign w_b = w_leaf[2*n + 1 - c_P];
        end else begin : g_from_node
            assign w_a = w_node[2*n];
            assign w_b = w_node[2*n + 1];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum <= '0;
            end else begin
                r_sum <= w_a + w_b;
            end
        end
        assign w_node[n] = r_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v_tree <= '0;
        end else begin
            r_v_tree[0] <= r_v_prod;
            for (int i = 1; i < c_T; i++) begin
                r_v_tree[i] <= r_v_tree[i-1];
            end
        end
    end

    logic signed [c_RND_W-1:0] w_rnd;
    logic signed [c_RND_W-1:0] w_shift;
    logic signed [DATA_W-1:0]  w_y;

    // One guard bit keeps the rounding offset from overflowing the accumulator
    assign w_rnd   = {w_node[1][c_ACC_W-1], w_node[1]} + c_HALF;
    assign w_shift = w_rnd >>> OUT_SHIFT;

`ifdef SRRC_SAT_EN
    localparam logic signed [c_RND_W-1:0] c_YMAX = {{(c_RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [c_RND_W-1:0] c_YMIN = {{(c_RND_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    always_comb begin
        w_y = w_shift[DATA_W-1:0];
        if (w_shift > c_YMAX) begin
            w_y = c_YMAX[DATA_W-1:0];
        end else if (w_shift < c_YMIN) begin
            w_y = c_YMIN[DATA_W-1:0];
        end
    end
`else
    logic w_unused_hi;

    assign w_y         = w_shift[DATA_W-1:0];
    assign w_unused_hi = ^w_shift[c_RND_W-1:DATA_W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            out_valid <= r_v_tree[c_T-1];
            if (r_v_tree[c_T-1]) begin
                y <= w_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_srrc_fir_sym_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_srrc_fir_sym_pipe
// Brief    : Self-checking bench for srrc_fir_sym_pipe (queue scoreboard,
//            direct-form reference model and hard-coded vector tables).
// Revision : 1.0 - initial release
// ============================================================================
module tb_srrc_fir_sym_pipe;

    localparam int DW  = 18;
    localparam int N   = 31;
    localparam int U   = 16;
    localparam int SH  = 17;
    localparam int LAT = 7;
`ifdef SRRC_SAT_EN
    localparam int c_OVF_Y = 131071;
`else
    localparam int c_OVF_Y = 131010;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic                 coef_we = 1'b0;
    logic [3:0]           coef_addr = '0;
    logic signed [17:0]   coef_data = '0;
    logic                 coef_commit = 1'b0;
    logic                 out_valid;
    logic signed [DW-1:0] y;

    srrc_fir_sym_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .x_in        (x_in),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_commit (coef_commit),
        .out_valid   (out_valid),
        .y           (y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_y = 0;

    typedef struct {
        int    y;
        int    k;
        string tag;
    } exp_t;

    typedef struct {
        int x;
        int y;
    } vec_t;

    exp_t  sb[$];
    string cur_tag = "reset";

    longint m_hist   [N];
    int     m_shadow [U];
    int     m_active [U];
    bit     pend_v = 1'b0;
    longint pend_hist[N];
    int     pend_k;
    bit     pend_use_tab;
    int     pend_tab_y;
    string  pend_tag;

    int imp_c [U] = '{0, 0, 0, 0, 0, 0, 0, 1208, -1252, -3878, -4525, -1463, 5416, 14158, 21475, 24324};
    vec_t pt_tab  [16];
    vec_t imp_tab [N];

    function automatic void model_reset();
        for (int j = 0; j < N; j++) m_hist[j] = 0;
        for (int i = 0; i < U; i++) begin
            m_shadow[i] = (i == U - 1) ? 131071 : 0;
            m_active[i] = m_shadow[i];
        end
        pend_v = 1'b0;
    endfunction

    // Direct-form reference: full tap sum, round half up, then wrap or clamp
    function automatic int fir_out();
        longint acc;
        longint r;
        acc = 0;
        for (int j = 0; j < N; j++) begin
            acc += pend_hist[j] * longint'(m_active[(j < N - 1 - j) ? j : N - 1 - j]);
        end
        r = (acc + (longint'(1) << (SH - 1))) >>> SH;
`ifdef SRRC_SAT_EN
        if (r > 131071) r = 131071;
        else if (r < -131072) r = -131072;
`else
        r = r & 64'h3FFFF;
        if (r >= 64'h20000) r = r - 64'h40000;
`endif
        return int'(r);
    endfunction

    // One clock of stimulus; the model finalises the previous sample only after
    // this cycle's commit, since a commit at edge c also applies to sample c-1.
    task automatic drive(input bit v, input int x, input bit use_tab, input int tab_y,
                         input bit we, input int addr, input int data, input bit commit);
        in_valid    = v;
        x_in        = x[DW-1:0];
        coef_we     = we;
        coef_addr   = addr[3:0];
        coef_data   = data[17:0];
        coef_commit = commit;
        if (we && addr < U) m_shadow[addr] = data;
        if (commit) for (int i = 0; i < U; i++) m_active[i] = m_shadow[i];
        if (pend_v) begin
            sb.push_back('{y: (pend_use_tab ? pend_tab_y : fir_out()), k: pend_k, tag: pend_tag});
            pend_v = 1'b0;
        end
        if (v) begin
            for (int j = N - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = x;
            for (int j = 0; j < N; j++) pend_hist[j] = m_hist[j];
            pend_v       = 1'b1;
            pend_k       = cyc + 1;
            pend_use_tab = use_tab;
            pend_tab_y   = tab_y;
            pend_tag     = cur_tag;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        for (int i = 0; i < n; i++) begin
            in_valid = i[0];
            x_in     = 18'(i * 777);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        x_in     = '0;
        rst_n    = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checks++;
            if (y !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: y=%0d out_valid=%b, required y=0 out_valid=0", y, out_valid);
            end
        end else if (out_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out: out_valid=%b y=%0d at cycle %0d, required no output", out_valid, y, cyc);
            end else begin
                e = sb.pop_front();
                checks += 2;
                last_y = int'(y);
                if (int'(y) != e.y) begin
                    errors++;
                    $display("FAIL %s_y: got %0d, required %0d (sample edge %0d)", e.tag, y, e.y, e.k);
                end
                if (cyc - e.k != LAT) begin
                    errors++;
                    $display("FAIL %s_latency: got %0d cycles, required %0d", e.tag, cyc - e.k, LAT);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            pt_tab[i].x = (i == 0) ? 1000 : 0;
            pt_tab[i].y = (i == 15) ? 1000 : 0;
        end
        for (int i = 0; i < N; i++) begin
            imp_tab[i].x = (i == 0) ? 131071 : 0;
            imp_tab[i].y = imp_c[(i < N - 1 - i) ? i : N - 1 - i];
        end

        cur_tag = "reset";
        do_reset(8);
        idle(12);

        cur_tag = "passthru";
        for (int i = 0; i < 16; i++) drive(1, pt_tab[i].x, 1, pt_tab[i].y, 0, 0, 0, 0);

        cur_tag = "flush";
        for (int i = 0; i < U; i++) drive(0, 0, 0, 0, 1, i, imp_c[i], 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < N; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);

        cur_tag = "impulse";
        for (int i = 0; i < N; i++) drive(1, imp_tab[i].x, 1, imp_tab[i].y, 0, 0, 0, 0);

        cur_tag = "gapped";
        for (int i = 0; i < N; i++) begin
            drive(1, imp_tab[i].x, 1, imp_tab[i].y, 0, 0, 0, 0);
            idle(2);
        end

        // Shadow writes while streaming, then commit with a write-through entry
        cur_tag = "commit";
        for (int t = 0; t < 40; t++) begin
            if (t < 15)       drive(1, 1000, 0, 0, 1, t, 2000 + 300 * t, 0);
            else if (t == 24) drive(1, 1000, 0, 0, 1, 15, -7000, 1);
            else              drive(1, 1000, 0, 0, 0, 0, 0, 0);
        end
        idle(10);

        cur_tag = "overflow";
        for (int i = 0; i < U; i++) drive(0, 0, 0, 0, 1, i, 131071, (i == U - 1));
        for (int t = 0; t < 45; t++) drive(1, 131071, 0, 0, 0, 0, 0, 0);
        idle(12);
        checks++;
        if (last_y != c_OVF_Y) begin
            errors++;
            $display("FAIL overflow_steady: got %0d, required %0d", last_y, c_OVF_Y);
        end

        cur_tag = "midreset";
        for (int t = 0; t < 5; t++) drive(1, 3000 + t, 0, 0, 0, 0, 0, 0);
        do_reset(3);
        idle(15);
        for (int t = 0; t < 20; t++) drive(1, 500 - 37 * t, 0, 0, 0, 0, 0, 0);
        idle(15);

        checks++;
        if (sb.size() != 0 || pend_v) begin
            errors++;
            $display("FAIL drain: %0d outputs still outstanding, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
